// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: START/FETCH/DECODE/EXEC/MEM/WB/TRAP with bus timeout.
// Optional retired-instruction counter enabled by defining RV_CTRL_INSTRET_EN.
module rv_multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

    state_t      state_q;
    logic [15:0] tmo_q;
    logic        illegal_q;
    logic        bus_err_q;

    logic        is_load, is_store, is_branch, is_fence, legal;
    logic [15:0] tmo_d;
    logic        tmo_hit;

    // Access width is resolved by the LSU, so funct3 plays no part in sequencing.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_fence  = (opcode == OPC_FENCE);

    always_comb begin
        case (opcode)
            OPC_OP, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
    end

    assign tmo_d   = tmo_q + 16'd1;
    assign tmo_hit = TMO_EN && !mem_ready && (tmo_d == TMO_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_START;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_START: begin
                    state_q <= S_FETCH;
                    tmo_q   <= '0;
                end
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        tmo_q <= '0;
                        if (state_q == S_FETCH) state_q <= S_DECODE;
                        else if (is_store)      state_q <= S_FETCH;
                        else                    state_q <= S_WB;
                    end else if (tmo_hit) begin
                        state_q   <= S_TRAP;
                        bus_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    tmo_q <= '0;
                    if (is_load || is_store)       state_q <= S_MEM;
                    else if (is_branch || is_fence) state_q <= S_FETCH;
                    else                           state_q <= S_WB;
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    tmo_q   <= '0;
                end
                default: state_q <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        alu_op       = 2'b00;

        // ALU selects stay stable from EXEC through WB so the result feeding the regfile/address holds.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (opcode)
                OPC_OP:              alu_op = 2'b01;
                OPC_IMM: begin
                    alu_b_sel = 1'b1;
                    alu_op    = 2'b01;
                end
                OPC_LOAD, OPC_STORE,
                OPC_JALR:            alu_b_sel = 1'b1;
                OPC_AUIPC: begin
                    alu_a_sel = 1'b1;
                    alu_b_sel = 1'b1;
                end
                OPC_BRANCH:          alu_op = 2'b10;
                default:             ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = {1'b0, br_taken};
                end else if (is_fence) begin
                    pc_we  = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                pc_we        = mem_ready && is_store;
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                case (opcode)
                    OPC_LOAD:          wb_sel = 2'b01;
                    OPC_JAL, OPC_JALR: wb_sel = 2'b10;
                    OPC_LUI:           wb_sel = 2'b11;
                    default:           wb_sel = 2'b00;
                endcase
                if (opcode == OPC_JAL)       pc_sel = 2'b01;
                else if (opcode == OPC_JALR) pc_sel = 2'b10;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state_o = state_q;

`ifdef RV_CTRL_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        instret_q <= '0;
        else if (pc_we) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: instruction sequencing, wait states, traps, timeout, async reset.
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst0;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        br_taken, mem_ready, mem_ready0;

  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic [1:0]  pc_sel, wb_sel, alu_op;
  logic        alu_a_sel, alu_b_sel, illegal, bus_err;
  logic [31:0] instret;
  logic [2:0]  state_o;

  logic        mem_req0, mem_we0, mem_addr_sel0, ir_we0, pc_we0, reg_we0;
  logic [1:0]  pc_sel0, wb_sel0, alu_op0;
  logic        alu_a_sel0, alu_b_sel0, illegal0, bus_err0;
  logic [31:0] instret0;
  logic [2:0]  state0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RV_CTRL_INSTRET_EN
  localparam bit IR_EN = 1'b1;
`else
  localparam bit IR_EN = 1'b0;
`endif

  // clock/reset block
  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .illegal(illegal),
    .bus_err(bus_err), .instret(instret), .state_o(state_o)
  );

  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(0)) u_dut_notmo (
    .clk(clk), .rst(rst0), .opcode(7'h33), .funct3(3'd0), .br_taken(1'b0),
    .mem_ready(mem_ready0), .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr_sel(mem_addr_sel0),
    .ir_we(ir_we0), .pc_we(pc_we0), .pc_sel(pc_sel0), .reg_we(reg_we0), .wb_sel(wb_sel0),
    .alu_a_sel(alu_a_sel0), .alu_b_sel(alu_b_sel0), .alu_op(alu_op0), .illegal(illegal0),
    .bus_err(bus_err0), .instret(instret0), .state_o(state0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock, then settle just after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    cyc();
    rst = 1'b0;
    #1;
    chk("start_state", 32'(state_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rst0 = 1'b1;
    opcode = 7'h33; funct3 = 3'd0; br_taken = 1'b0;
    mem_ready = 1'b1; mem_ready0 = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_instret", instret, 32'd0);
    cyc();
    rst0 = 1'b0;

    // ADD 0x002081B3, zero wait states
    release_reset();
    cyc(); chk("add_fetch", 32'(state_o), 32'd1);
    chk("add_mem_req", 32'(mem_req), 32'd1);
    chk("add_ir_we", 32'(ir_we), 32'd1);
    chk("add_addr_sel", 32'(mem_addr_sel), 32'd0);
    cyc(); chk("add_decode", 32'(state_o), 32'd2);
    chk("add_dec_req", 32'(mem_req), 32'd0);
    cyc(); chk("add_exec", 32'(state_o), 32'd3);
    chk("add_alu_op", 32'(alu_op), 32'd1);
    chk("add_alu_b", 32'(alu_b_sel), 32'd0);
    cyc(); chk("add_wb", 32'(state_o), 32'd5);
    chk("add_reg_we", 32'(reg_we), 32'd1);
    chk("add_wb_sel", 32'(wb_sel), 32'd0);
    chk("add_pc_we", 32'(pc_we), 32'd1);
    cyc(); chk("add_refetch", 32'(state_o), 32'd1);
    chk("add_instret", instret, IR_EN ? 32'd1 : 32'd0);

    // LW 0x0000A103 with two MEM wait states
    opcode = 7'h03;
    #1;
    chk("lw_ir_we", 32'(ir_we), 32'd1);
    cyc(); cyc(); chk("lw_exec", 32'(state_o), 32'd3);
    chk("lw_alu_b", 32'(alu_b_sel), 32'd1);
    chk("lw_alu_op", 32'(alu_op), 32'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) mem_ready = 1'b1;
      #1;
      chk("lw_mem_state", 32'(state_o), 32'd4);
      chk("lw_mem_req", 32'(mem_req), 32'd1);
      chk("lw_addr_sel", 32'(mem_addr_sel), 32'd1);
      chk("lw_mem_we", 32'(mem_we), 32'd0);
      chk("lw_mem_pc_we", 32'(pc_we), 32'd0);
    end
    cyc(); chk("lw_wb", 32'(state_o), 32'd5);
    chk("lw_wb_sel", 32'(wb_sel), 32'd1);
    chk("lw_reg_we", 32'(reg_we), 32'd1);
    cyc(); chk("lw_refetch", 32'(state_o), 32'd1);
    chk("lw_instret", instret, IR_EN ? 32'd2 : 32'd0);

    // BEQ taken then not taken
    opcode = 7'h63;
    br_taken = 1'b1;
    cyc(); cyc(); chk("beq_t_exec", 32'(state_o), 32'd3);
    chk("beq_t_pc_we", 32'(pc_we), 32'd1);
    chk("beq_t_pc_sel", 32'(pc_sel), 32'd1);
    chk("beq_t_alu_op", 32'(alu_op), 32'd2);
    chk("beq_t_reg_we", 32'(reg_we), 32'd0);
    cyc(); chk("beq_t_next", 32'(state_o), 32'd1);
    br_taken = 1'b0;
    cyc(); cyc(); chk("beq_n_exec", 32'(state_o), 32'd3);
    chk("beq_n_pc_we", 32'(pc_we), 32'd1);
    chk("beq_n_pc_sel", 32'(pc_sel), 32'd0);
    cyc(); chk("beq_n_next", 32'(state_o), 32'd1);
    chk("beq_instret", instret, IR_EN ? 32'd4 : 32'd0);

    // JALR
    opcode = 7'h67;
    cyc(); cyc(); chk("jalr_alu_b", 32'(alu_b_sel), 32'd1);
    cyc(); chk("jalr_wb", 32'(state_o), 32'd5);
    chk("jalr_pc_sel", 32'(pc_sel), 32'd2);
    chk("jalr_wb_sel", 32'(wb_sel), 32'd2);
    cyc(); chk("jalr_instret", instret, IR_EN ? 32'd5 : 32'd0);

    // SW interrupted by async reset in MEM
    opcode = 7'h23;
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc(); chk("sw_mem", 32'(state_o), 32'd4);
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_addr_sel", 32'(mem_addr_sel), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("sw_rst_state", 32'(state_o), 32'd0);
    chk("sw_rst_req", 32'(mem_req), 32'd0);
    chk("sw_rst_we", 32'(mem_we), 32'd0);
    chk("sw_rst_instret", instret, 32'd0);
    mem_ready = 1'b1;
    release_reset();
    cyc(); chk("sw_post_fetch", 32'(state_o), 32'd1);

    // ECALL and all-zero word trap as illegal
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 7'h73 : 7'h00;
      cyc(); chk("ill_decode", 32'(state_o), 32'd2);
      cyc(); chk("ill_trap", 32'(state_o), 32'd6);
      chk("ill_flag", 32'(illegal), 32'd1);
      for (int i = 0; i < 20; i++) begin
        cyc();
        chk("ill_no_req", 32'(mem_req), 32'd0);
        chk("ill_hold", 32'(state_o), 32'd6);
      end
      rst = 1'b1;
      #1;
      chk("ill_cleared", 32'(illegal), 32'd0);
      release_reset();
      cyc(); chk("ill_fetch", 32'(state_o), 32'd1);
    end

    // Bus timeout: 4 FETCH wait cycles then TRAP
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    release_reset();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("tmo_fetch", 32'(state_o), 32'd1);
      chk("tmo_bus_err_lo", 32'(bus_err), 32'd0);
    end
    cyc(); chk("tmo_trap", 32'(state_o), 32'd6);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_req_drop", 32'(mem_req), 32'd0);
    chk("tmo_illegal", 32'(illegal), 32'd0);

    // Timeout disabled instance has waited since start; push it past 255 cycles
    for (int i = 0; i < 300; i++) cyc();
    chk("notmo_state", 32'(state0), 32'd1);
    chk("notmo_req", 32'(mem_req0), 32'd1);
    chk("notmo_bus_err", 32'(bus_err0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
